// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle CPU sequencing controller (optional perf counters: MC_PERF_CNT_EN)
// Registered state, combinational strobes; traps on illegal opcode or memory timeout.
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       reg_we,
  output logic       reg_dst_ra,
  output logic       alu_src_imm,
  output logic [2:0] state,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          trap_q, trap_d;
  logic [1:0]    cause_q, cause_d;
  logic          op_legal, op_imm;

  always_comb begin
    op_legal = 1'b0;
    op_imm   = 1'b0;
    case (op)
      OP_R, OP_BEQ, OP_BNE, OP_J, OP_JAL: op_legal = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: begin
        op_legal = 1'b1;
        op_imm   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    trap_d      = trap_q;
    cause_d     = cause_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    reg_dst_ra  = 1'b0;
    alu_src_imm = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (op == OP_J || op == OP_JAL) begin
          pc_we      = 1'b1;
          pc_src     = 2'd2;
          reg_we     = (op == OP_JAL);
          reg_dst_ra = (op == OP_JAL);
          state_d    = S_FETCH;
        end else if (!op_legal) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_imm = op_imm;
        if (op == OP_BEQ || op == OP_BNE) begin
          pc_we   = (op == OP_BEQ) ? zero : ~zero;
          pc_src  = 2'd1;
          state_d = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_SW);
        if (mem_ready) begin
          state_d = (op == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        reg_we      = 1'b1;
        alu_src_imm = op_imm;
        state_d     = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter only runs while a request is outstanding, so it is zero on every FETCH/MEM entry.
  always_comb begin
    wait_d = '0;
    if (mem_req && !mem_ready) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;
  logic        instr_done;

  assign instr_done = (state_d == S_FETCH) &&
                      (state_q == S_DECODE || state_q == S_EXEC ||
                       state_q == S_MEM || state_q == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
// Instruction-level schedule model builds expected per-cycle outputs; one process compares.
module tb_multicycle_control_fsm;

  localparam int TO = 4;

  localparam logic [5:0] R_OP = 6'b000000, ADDI = 6'b001000, ANDI = 6'b001100,
                         ORI = 6'b001101, XORI = 6'b001110, LUI = 6'b001111,
                         LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011,
                         BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, pc_we, ir_we, reg_we, reg_dst_ra, alu_src_imm, trap;
  logic [1:0] pc_src, trap_cause;
  logic [2:0] state;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(TO), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we), .pc_src(pc_src),
    .ir_we(ir_we), .reg_we(reg_we), .reg_dst_ra(reg_dst_ra),
    .alu_src_imm(alu_src_imm), .state(state), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [14:0] exp;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        cur;
  logic [4:0]  seen[$];
  logic        chk = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic        m_trap = 1'b0;
  logic [1:0]  m_cause = 2'b00;
  logic [14:0] act;

  assign act = {state, mem_req, mem_we, pc_we, pc_src, ir_we, reg_we, reg_dst_ra,
                alu_src_imm, trap, trap_cause};

  always @(negedge clk) begin
    if (chk) begin
      checks++;
      seen.push_back({state, mem_req, reg_we});
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL cycle op=%b st_want=%0d: got %b want %b (state,req,we,pcwe,pcsrc,ir,reg,ra,imm,trap,cause)",
                 cur.op, cur.exp[14:12], act, cur.exp);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic z, input logic rdy, input logic [2:0] st,
                     input logic mreq, input logic mwe, input logic pcwe, input logic [1:0] pcsrc,
                     input logic irwe, input logic regwe, input logic ra, input logic imm);
    cyc_t c;
    c.op  = o;
    c.z   = z;
    c.rdy = rdy;
    c.exp = {st, mreq, mwe, pcwe, pcsrc, irwe, regwe, ra, imm, m_trap, m_cause};
    q.push_back(c);
  endtask

  function automatic logic is_legal(input logic [5:0] o);
    return o inside {R_OP, ADDI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL};
  endfunction

  // fw/mw: cycles memory keeps mem_ready low in fetch / data access.
  task automatic gen_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
    logic imm, st, ld, taken;
    imm = o inside {ADDI, ANDI, ORI, XORI, LUI, LW, SW};
    st  = (o == SW);
    ld  = (o == LW);
    for (int i = 0; i < fw; i++) add(o, z, 0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0);
    add(o, z, 1, 1, 1, 0, 1, 2'd0, 1, 0, 0, 0);
    if (!is_legal(o)) begin
      add(o, z, 1, 2, 0, 0, 0, 2'd0, 0, 0, 0, 0);
      m_trap  = 1'b1;
      m_cause = 2'b01;
      return;
    end
    if (o == J || o == JAL) begin
      add(o, z, 1, 2, 0, 0, 1, 2'd2, 0, o == JAL, o == JAL, 0);
      return;
    end
    add(o, z, 1, 2, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    if (o == BEQ || o == BNE) begin
      taken = (o == BEQ) ? z : !z;
      add(o, z, 1, 3, 0, 0, taken, 2'd1, 0, 0, 0, 0);
      return;
    end
    add(o, z, 1, 3, 0, 0, 0, 2'd0, 0, 0, 0, imm);
    if (ld || st) begin
      for (int i = 0; i < mw; i++) add(o, z, 0, 4, 1, st, 0, 2'd0, 0, 0, 0, 0);
      add(o, z, 1, 4, 1, st, 0, 2'd0, 0, 0, 0, 0);
      if (st) return;
    end
    add(o, z, 1, 5, 0, 0, 0, 2'd0, 0, 1, 0, imm);
  endtask

  task automatic gen_trap(input int n);
    for (int i = 0; i < n; i++) add(ADDI, 0, 1, 7, 0, 0, 0, 2'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    lit("reset_outputs", {17'd0, act}, 32'd0);
    m_trap  = 1'b0;
    m_cause = 2'b00;
    op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen.delete();
  endtask

  // First record is applied in the cycle reset releases (the IDLE cycle).
  task automatic run_q();
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      op = q[i].op; zero = q[i].z; mem_ready = q[i].rdy;
      cur = q[i];
      chk = 1'b1;
    end
    @(negedge clk);
    #1;
    chk = 1'b0;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_st[5];
    exp_st = '{1, 2, 3, 5, 1};

    do_reset();
    add(R_OP, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    gen_instr(ADDI, 0, 0, 0);
    gen_instr(ADDI, 0, 0, 0);
    gen_instr(LW, 0, 0, 3);
    gen_instr(SW, 0, 0, 1);
    gen_instr(BEQ, 1, 0, 0);
    gen_instr(BEQ, 0, 0, 0);
    gen_instr(BNE, 0, 0, 0);
    gen_instr(BNE, 1, 0, 0);
    gen_instr(J, 0, 0, 0);
    gen_instr(JAL, 0, 0, 0);
    gen_instr(R_OP, 0, 0, 0);
    gen_instr(ANDI, 0, 0, 0);
    gen_instr(ORI, 0, 0, 0);
    gen_instr(XORI, 0, 0, 0);
    gen_instr(LUI, 0, 0, 0);
    gen_instr(ADDI, 0, TO - 1, 0);
    gen_instr(BAD, 0, 0, 0);
    gen_trap(3);
    run_q();

    for (int k = 0; k < 5; k++) lit($sformatf("addi_state%0d", k), {29'd0, seen[k+1][4:2]}, exp_st[k]);
    n = 0;
    for (int k = 1; k <= 4; k++) n += int'(seen[k][0]);
    lit("addi_reg_we_cycles", n, 1);
    n = 0;
    for (int k = 9; k <= 16; k++) if (seen[k][4:2] == 3'd4 && seen[k][1]) n++;
    lit("lw_mem_req_cycles", n, 4);
    lit("lw_then_wb", {29'd0, seen[16][4:2]}, 5);
    lit("illegal_trap", {31'd0, trap}, 1);
    lit("illegal_cause", {30'd0, trap_cause}, 2'b01);

    do_reset();
    add(R_OP, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) add(ADDI, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0);
    m_trap  = 1'b1;
    m_cause = 2'b10;
    gen_trap(3);
    run_q();
    lit("timeout_cause", {30'd0, trap_cause}, 2'b10);

    do_reset();
    add(R_OP, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    gen_instr(LW, 0, 0, 2);
    void'(q.pop_back());
    void'(q.pop_back());
    void'(q.pop_back());
    run_q();
    lit("pre_reset_state_mem", {29'd0, state}, 4);
    lit("pre_reset_mem_req", {31'd0, mem_req}, 1);
    rst_n = 1'b0;
    #1;
    lit("async_reset_state", {29'd0, state}, 0);
    lit("async_reset_mem_req", {31'd0, mem_req}, 0);
    do_reset();
    add(R_OP, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    gen_instr(ADDI, 0, 0, 0);
    run_q();
    lit("restart_fetch", {29'd0, seen[1][4:2]}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
